instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning instruction-memory byte-address width.
REQ-002 SHALL have parameter BASE_RST, default 0, meaning address counter value after reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  encode request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port instr_type  input  instr_type_e  format selector (R/I/S/B/U/J/INVALID) from the shared structures package.
REQ-008 SHALL have ports opcode  input  7;  funct3  input  3;  funct7  input  7;  rd, rs1, rs2  input  5 each;  imm  input  32  instruction fields.
REQ-009 SHALL have port base_load  input  1  and port base_addr  input  ADDR_W; base_load loads the address counter.
REQ-010 SHALL have ports out_valid  output  1;  out_ready  input  1;  out_addr  output  ADDR_W;  out_data  output  32  encoded-word stream to instruction memory.
REQ-011 SHALL have ports err  output  1  (sticky) and err_clr  input  1.

Function
REQ-012 SHALL encode on acceptance: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]|rs1|funct3|rd|opcode; S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-013 SHALL encode B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; U = imm[31:12]|rd|opcode; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-014 SHALL tag each accepted word with the current address counter, then increment the counter by 4, wrapping modulo 2^ADDR_W.
REQ-015 SHALL buffer {addr,data} pairs in a 2-entry FIFO; req_ready = (count < 2), independent of out_ready in the same cycle.
REQ-016 SHALL drive out_valid = (count > 0), with out_addr/out_data from the FIFO head; pop on out_valid and out_ready.
REQ-017 SHALL present an accepted word on out_valid exactly 1 cycle after acceptance when the FIFO was empty (latency 1, registered outputs).
REQ-018 SHALL hold out_addr/out_data stable while out_valid is high and out_ready is low.
REQ-019 SHALL support simultaneous push and pop when count is 1 (count stays 1, order preserved).
REQ-020 SHALL, on INVALID instr_type accepted: push nothing, leave the counter unchanged, and set err.
REQ-021 SHALL, on B or J with imm[0]=1: encode normally (imm[0] discarded) and set err.
REQ-022 SHALL, on base_load coinciding with acceptance: tag the accepted word with the old counter, then set the counter to base_addr (load overrides increment).
REQ-023 SHALL leave FIFO contents unaffected by base_load.
REQ-024 SHALL clear err on err_clr; when err_clr coincides with a new error, err SHALL remain 1.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force count=0, out_valid=0, req_ready=0, err=0, counter=BASE_RST, out_addr=0, out_data=0.
REQ-026 SHALL raise req_ready in the first cycle after rst_n deasserts; reset mid-stream SHALL discard buffered words.

Verification
REQ-027 SHALL cover: R ADD rd=3,rs1=1,rs2=2, f3=0, f7=0, opc=0x33, after reset -> next cycle out_valid=1, out_addr=0x0, out_data=0x002081B3.
REQ-028 SHALL cover: back-to-back I ADDI x1,x0,5 (opc 0x13) then S SW x2,8(x1) (opc 0x23, f3=2) -> words 0x00500093 @0x0, 0x0020A423 @0x4.
REQ-029 SHALL cover: J JAL x1,+8 (opc 0x6F) -> 0x008000EF; B BEQ x1,x2,-4 (opc 0x63) -> 0xFE208EE3; err stays 0.
REQ-030 SHALL cover: out_ready=0 for 4 cycles with req_valid=1 -> 2 words accepted, req_ready=0, out_data held; out_ready=1 -> drains in order.
REQ-031 SHALL cover: INVALID type, then B with imm=3 -> err=1, no word pushed for INVALID, counter advanced by 4 only; err_clr -> err=0.
REQ-032 SHALL cover: base_load with base_addr=0x100 coincident with acceptance at counter 0x8 -> word tagged 0x8, next word tagged 0x100; rst_n pulse with 2 buffered -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RISC-V instruction encoder: packs R/I/S/B/U/J fields into 32-bit words and
// streams {address, word} pairs to instruction memory through a 2-entry FIFO.

package instr_encoder_pkg;
  typedef enum logic [2:0] {
    IT_R       = 3'd0,
    IT_I       = 3'd1,
    IT_S       = 3'd2,
    IT_B       = 3'd3,
    IT_U       = 3'd4,
    IT_J       = 3'd5,
    IT_INVALID = 3'd6
  } instr_type_e;
endpackage

module instr_encoder_loader
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  instr_type_e       instr_type,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              err,
  input  logic              err_clr
);

  logic [31:0]       enc_word;
  logic              type_ok;
  logic              align_err;
  logic              accept;
  logic              push;
  logic              pop;

  logic              ready_q, ready_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [31:0]       head_data_q, head_data_d;
  logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
  logic [31:0]       tail_data_q, tail_data_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc_word  = '0;
    type_ok   = 1'b1;
    align_err = 1'b0;
    case (instr_type)
      IT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      IT_I: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      IT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IT_B: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        align_err = imm[0];
      end
      IT_U: enc_word = {imm[31:12], rd, opcode};
      IT_J: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        align_err = imm[0];
      end
      default: type_ok = 1'b0;
    endcase
  end

  // req_ready is held low through reset and the edge that releases it.
  assign req_ready = ready_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_addr  = head_addr_q;
  assign out_data  = head_data_q;
  assign err       = err_q;

  assign accept = req_valid & req_ready;
  assign push   = accept & type_ok;
  assign pop    = out_valid & out_ready;

  always_comb begin
    ready_d     = 1'b1;
    count_d     = count_q;
    ctr_d       = ctr_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    tail_addr_d = tail_addr_q;
    tail_data_d = tail_data_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Head is the output register; a push goes there when it is free or being vacated.
    if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
      head_addr_d = ctr_q;
      head_data_d = enc_word;
    end else if (push) begin
      tail_addr_d = ctr_q;
      tail_data_d = enc_word;
    end else if (pop && count_q == 2'd2) begin
      head_addr_d = tail_addr_q;
      head_data_d = tail_data_q;
    end

    if (push)      ctr_d = ctr_q + ADDR_W'(4);
    if (base_load) ctr_d = base_addr;

    err_d = (accept & (~type_ok | align_err)) | (err_q & ~err_clr);
  end

  // NOTE: the FIFO storage is reset because out_addr/out_data must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      count_q     <= 2'd0;
      ctr_q       <= BASE_RST;
      err_q       <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
      tail_addr_q <= '0;
      tail_data_q <= '0;
    end else begin
      ready_q     <= ready_d;
      count_q     <= count_d;
      ctr_q       <= ctr_d;
      err_q       <= err_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      tail_addr_q <= tail_addr_d;
      tail_data_q <= tail_data_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader against a queue-based
// reference model of the encoder, address counter, FIFO and sticky error.

module tb_instr_encoder_loader;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  instr_type_e instr_type = IT_R;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        err;
  logic        err_clr = 1'b0;

  instr_encoder_loader #(.ADDR_W(32), .BASE_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .instr_type(instr_type), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .base_load(base_load), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rv;
    int        t;
    bit [31:0] opc, f3, f7, rd, rs1, rs2, imm;
    bit        ordy;
    bit        bl;
    bit [31:0] ba;
    bit        ec;
  } stim_t;

  typedef struct {
    bit [31:0] a;
    bit [31:0] d;
  } word_t;

  word_t     q[$];
  bit [31:0] m_ctr;
  bit        m_err;
  bit        m_rdy;
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction formats written as shift-and-mask arithmetic on the field values.
  function automatic bit [31:0] ref_encode(stim_t s);
    bit [31:0] regs;
    regs = (s.rs2 << 20) | (s.rs1 << 15) | (s.f3 << 12);
    case (s.t)
      0: return (s.f7 << 25) | regs | (s.rd << 7) | s.opc;
      1: return ((s.imm & 32'hFFF) << 20) | (s.rs1 << 15) | (s.f3 << 12) | (s.rd << 7) | s.opc;
      2: return (((s.imm >> 5) & 32'h7F) << 25) | regs | ((s.imm & 32'h1F) << 7) | s.opc;
      3: return (((s.imm >> 12) & 32'h1) << 31) | (((s.imm >> 5) & 32'h3F) << 25) | regs
                | (((s.imm >> 1) & 32'hF) << 8) | (((s.imm >> 11) & 32'h1) << 7) | s.opc;
      4: return (s.imm & 32'hFFFF_F000) | (s.rd << 7) | s.opc;
      5: return (((s.imm >> 20) & 32'h1) << 31) | (((s.imm >> 1) & 32'h3FF) << 21)
                | (((s.imm >> 11) & 32'h1) << 20) | (((s.imm >> 12) & 32'hFF) << 12)
                | (s.rd << 7) | s.opc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic stim_t idle(bit ordy);
    stim_t s;
    s = '{rv: 1'b0, t: 0, opc: 0, f3: 0, f7: 0, rd: 0, rs1: 0, rs2: 0, imm: 0,
          ordy: ordy, bl: 1'b0, ba: 0, ec: 1'b0};
    return s;
  endfunction

  function automatic stim_t mk(int t, bit [31:0] opc, bit [31:0] f3, bit [31:0] f7,
                               bit [31:0] rd_v, bit [31:0] rs1_v, bit [31:0] rs2_v,
                               bit [31:0] imm_v);
    stim_t s;
    s = idle(1'b1);
    s.rv = 1'b1; s.t = t; s.opc = opc; s.f3 = f3; s.f7 = f7;
    s.rd = rd_v; s.rs1 = rs1_v; s.rs2 = rs2_v; s.imm = imm_v;
    return s;
  endfunction

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input stim_t s);
    bit m_ready, acc, pop, ok_type;
    req_valid  = s.rv;
    instr_type = instr_type_e'(s.t[2:0]);
    opcode     = s.opc[6:0];
    funct3     = s.f3[2:0];
    funct7     = s.f7[6:0];
    rd         = s.rd[4:0];
    rs1        = s.rs1[4:0];
    rs2        = s.rs2[4:0];
    imm        = s.imm;
    out_ready  = s.ordy;
    base_load  = s.bl;
    base_addr  = s.ba;
    err_clr    = s.ec;
    @(negedge clk);
    m_ready = m_rdy && (q.size() < 2);
    check("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    check("err", {31'b0, err}, {31'b0, m_err});
    if (q.size() > 0) begin
      check("out_addr", out_addr, q[0].a);
      check("out_data", out_data, q[0].d);
    end
    acc     = s.rv && m_ready;
    pop     = (q.size() > 0) && s.ordy;
    ok_type = (s.t >= 0) && (s.t <= 5);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && ok_type) begin
      q.push_back('{a: m_ctr, d: ref_encode(s)});
      m_ctr = m_ctr + 32'd4;
    end
    if (s.bl) m_ctr = s.ba;
    m_err = (acc && (!ok_type || ((s.t == 3 || s.t == 5) && s.imm[0]))) || (m_err && !s.ec);
    m_rdy = 1'b1;
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    base_load = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    q.delete();
    m_ctr = 32'h0;
    m_err = 1'b0;
    m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    m_rdy = 1'b1;
    #1;
  endtask

  initial begin
    stim_t s;
    #2;
    apply_reset();

    // R ADD x3,x1,x2 straight after reset.
    cycle(mk(0, 32'h33, 0, 0, 3, 1, 2, 0));
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_addr", out_addr, 32'h0);
    check("add_data", out_data, 32'h002081B3);
    cycle(idle(1'b1));

    // ADDI x1,x0,5 then SW x2,8(x1) back to back.
    apply_reset();
    cycle(mk(1, 32'h13, 0, 0, 1, 0, 0, 5));
    check("addi_data", out_data, 32'h00500093);
    check("addi_addr", out_addr, 32'h0);
    cycle(mk(2, 32'h23, 2, 0, 0, 1, 2, 8));
    check("sw_data", out_data, 32'h0020A423);
    check("sw_addr", out_addr, 32'h4);

    // JAL x1,+8 and BEQ x1,x2,-4 with even offsets leave err clear.
    cycle(mk(5, 32'h6F, 0, 0, 1, 0, 0, 8));
    check("jal_data", out_data, 32'h008000EF);
    cycle(mk(3, 32'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC));
    check("beq_data", out_data, 32'hFE208EE3);
    check("beq_err", {31'b0, err}, 32'd0);
    cycle(idle(1'b1));

    // Backpressure: four requests against a stalled sink.
    for (int i = 0; i < 4; i++) begin
      s = mk(1, 32'h13, 0, 0, i + 1, 0, 0, i + 1);
      s.ordy = 1'b0;
      cycle(s);
      check("bp_head_held", out_data, 32'h00100093);
    end
    check("bp_ready_low", {31'b0, req_ready}, 32'd0);
    repeat (3) cycle(idle(1'b1));

    // INVALID then misaligned B: only the B word is pushed, err sticks until cleared.
    apply_reset();
    cycle(mk(6, 32'h63, 0, 0, 0, 1, 2, 0));
    check("inv_no_push", {31'b0, out_valid}, 32'd0);
    cycle(mk(3, 32'h63, 0, 0, 0, 1, 2, 3));
    check("b_odd_err", {31'b0, err}, 32'd1);
    check("b_odd_addr", out_addr, 32'h0);
    cycle(mk(0, 32'h33, 0, 0, 3, 1, 2, 0));
    check("after_err_addr", out_addr, 32'h4);
    s = idle(1'b1); s.ec = 1'b1;
    cycle(s);
    check("err_cleared", {31'b0, err}, 32'd0);
    s = mk(6, 0, 0, 0, 0, 0, 0, 0); s.ec = 1'b1;
    cycle(s);
    check("clr_vs_new_err", {31'b0, err}, 32'd1);
    s = idle(1'b1); s.ec = 1'b1;
    cycle(s);

    // Counter load coinciding with acceptance at 0x8.
    apply_reset();
    cycle(mk(4, 32'h37, 0, 0, 5, 0, 0, 32'h12345000));
    cycle(mk(4, 32'h37, 0, 0, 6, 0, 0, 32'hABCDE000));
    s = mk(0, 32'h33, 0, 32'h20, 7, 8, 9, 0); s.bl = 1'b1; s.ba = 32'h100;
    cycle(s);
    check("load_tag_old", out_addr, 32'h8);
    cycle(mk(0, 32'h33, 0, 0, 1, 2, 3, 0));
    check("load_tag_new", out_addr, 32'h100);

    // Address wrap at the top of the address space.
    s = idle(1'b1); s.bl = 1'b1; s.ba = 32'hFFFF_FFFC;
    cycle(s);
    cycle(mk(1, 32'h13, 0, 0, 1, 0, 0, 1));
    check("wrap_top", out_addr, 32'hFFFF_FFFC);
    cycle(mk(1, 32'h13, 0, 0, 2, 0, 0, 2));
    check("wrap_zero", out_addr, 32'h0);

    // Two words buffered, then a reset pulse discards them.
    for (int i = 0; i < 2; i++) begin
      s = mk(0, 32'h33, 0, 0, i, 1, 2, 0);
      s.ordy = 1'b0;
      cycle(s);
    end
    apply_reset();
    cycle(idle(1'b1));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s.rv   = ($urandom_range(0, 3) != 0);
      s.t    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      s.opc  = $urandom_range(0, 127);
      s.f3   = $urandom_range(0, 7);
      s.f7   = $urandom_range(0, 127);
      s.rd   = $urandom_range(0, 31);
      s.rs1  = $urandom_range(0, 31);
      s.rs2  = $urandom_range(0, 31);
      s.imm  = $urandom;
      s.ordy = ($urandom_range(0, 1) == 1);
      s.bl   = ($urandom_range(0, 19) == 0);
      s.ba   = $urandom;
      s.ec   = ($urandom_range(0, 7) == 0);
      cycle(s);
    end
    repeat (3) cycle(idle(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
